// File: rtl/ad9361_axis_pktzr_if.sv
// ad9361_axis_pktzr_if: 128-bit AXI-stream bundle used by the packetizer.
//   master : drives tvalid/tdata/tlast, samples tready (packet output side)
//   slave  : samples tvalid/tdata, drives tready (sample input side; the
//            upstream sample stream carries no framing, so tlast is not part
//            of the slave view)
interface ad9361_axis_pktzr_if #(
    parameter int DATA_W = 128
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/ad9361_axis_pktzr.sv
// ad9361_axis_pktzr: packetizer for the dual-AD9361 serializer sample stream.
// Emits one header beat {SYNC_WORD, seq, timestamp} followed by PKT_BEATS
// payload beats passed straight through from the upstream stream.
//
// Ports
//   clk        stream clock (serializer output clock)
//   rst        asynchronous, active-high reset
//   s_axis     upstream 128-bit sample stream (slave view)
//   m_axis     packet stream toward the DMA/host link (master view)
//   pkt_count  completed packets, equal to the current sequence number
//
// Build option
//   AD9361_PKTZR_TRAILER_EN  appends a trailer beat carrying the XOR of the
//                            packet's payload beats; tlast moves to the trailer.
module ad9361_axis_pktzr #(
    parameter int unsigned PKT_BEATS = 64,
    parameter logic [31:0] SYNC_WORD = 32'hA5A5_5A5A
) (
    input  logic                       clk,
    input  logic                       rst,
    ad9361_axis_pktzr_if.slave         s_axis,
    ad9361_axis_pktzr_if.master        m_axis,
    output logic [31:0]                pkt_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] PAY  = 2'd2;
`ifdef AD9361_PKTZR_TRAILER_EN
    localparam logic [1:0] TRL  = 2'd3;
`endif
    localparam logic [15:0] LAST_BEAT = 16'(PKT_BEATS - 1);

    logic [1:0]  state_q, state_d;
    logic [63:0] ts_cnt_q, ts_cnt_d;
    logic [63:0] ts_lat_q, ts_lat_d;
    logic [31:0] seq_q, seq_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
`ifdef AD9361_PKTZR_TRAILER_EN
    logic [127:0] acc_q, acc_d;
`endif

    assign pkt_count = seq_q;

    always_comb begin
        state_d       = state_q;
        ts_cnt_d      = ts_cnt_q + 64'd1;
        ts_lat_d      = ts_lat_q;
        seq_d         = seq_q;
        beat_cnt_d    = beat_cnt_q;
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        m_axis.tdata  = '0;
`ifdef AD9361_PKTZR_TRAILER_EN
        acc_d         = acc_q;
`endif
        case (state_q)
            IDLE: begin
                // Upstream is held off here; its first valid only starts a packet.
                if (s_axis.tvalid) begin
                    ts_lat_d = ts_cnt_q;
                    state_d  = HDR;
                end
            end
            HDR: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = {SYNC_WORD, seq_q, ts_lat_q};
`ifdef AD9361_PKTZR_TRAILER_EN
                acc_d         = '0;
`endif
                if (m_axis.tready) begin
                    beat_cnt_d = '0;
                    state_d    = PAY;
                end
            end
            PAY: begin
                // Zero-latency pass-through: handshake is simply forwarded.
                m_axis.tvalid = s_axis.tvalid;
                s_axis.tready = m_axis.tready;
                m_axis.tdata  = s_axis.tdata;
`ifndef AD9361_PKTZR_TRAILER_EN
                m_axis.tlast  = (beat_cnt_q == LAST_BEAT);
`endif
                if (s_axis.tvalid && m_axis.tready) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
`ifdef AD9361_PKTZR_TRAILER_EN
                    acc_d      = acc_q ^ s_axis.tdata;
                    if (beat_cnt_q == LAST_BEAT) state_d = TRL;
`else
                    if (beat_cnt_q == LAST_BEAT) begin
                        seq_d   = seq_q + 32'd1;
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef AD9361_PKTZR_TRAILER_EN
            TRL: begin
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = 1'b1;
                m_axis.tdata  = acc_q;
                if (m_axis.tready) begin
                    seq_d   = seq_q + 32'd1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ts_cnt_q   <= '0;
            ts_lat_q   <= '0;
            seq_q      <= '0;
            beat_cnt_q <= '0;
`ifdef AD9361_PKTZR_TRAILER_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ts_cnt_q   <= ts_cnt_d;
            ts_lat_q   <= ts_lat_d;
            seq_q      <= seq_d;
            beat_cnt_q <= beat_cnt_d;
`ifdef AD9361_PKTZR_TRAILER_EN
            acc_q      <= acc_d;
`endif
        end
    end
endmodule

// File: tb/tb_ad9361_axis_pktzr.sv
// Bench for ad9361_axis_pktzr. Four instances with PKT_BEATS = 4, 64, 1, 2
// share clk/rst; only the selected one sees traffic. A packet-format model
// (header, PKT_BEATS payloads in arrival order, optional XOR trailer) checks
// every output handshake.
module tb_ad9361_axis_pktzr;
    localparam logic [31:0]  SYNC  = 32'hA5A5_5A5A;
    localparam logic [127:0] PAT_A = {8{16'hF0F0}};
    localparam logic [127:0] PAT_B = {8{16'h0FF0}};
`ifdef AD9361_PKTZR_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int           sel;
    logic         sv, mr;
    logic [127:0] sd;
    logic         o_valid, o_last, s_ready;
    logic [127:0] o_data;
    logic [31:0]  o_cnt;
    logic [31:0]  pc0, pc1, pc2, pc3;

    ad9361_axis_pktzr_if si0 (); ad9361_axis_pktzr_if mi0 ();
    ad9361_axis_pktzr_if si1 (); ad9361_axis_pktzr_if mi1 ();
    ad9361_axis_pktzr_if si2 (); ad9361_axis_pktzr_if mi2 ();
    ad9361_axis_pktzr_if si3 (); ad9361_axis_pktzr_if mi3 ();

    assign si0.tvalid = sv && (sel == 0); assign si0.tdata = sd; assign si0.tlast = 1'b0;
    assign si1.tvalid = sv && (sel == 1); assign si1.tdata = sd; assign si1.tlast = 1'b0;
    assign si2.tvalid = sv && (sel == 2); assign si2.tdata = sd; assign si2.tlast = 1'b0;
    assign si3.tvalid = sv && (sel == 3); assign si3.tdata = sd; assign si3.tlast = 1'b0;
    assign mi0.tready = mr && (sel == 0);
    assign mi1.tready = mr && (sel == 1);
    assign mi2.tready = mr && (sel == 2);
    assign mi3.tready = mr && (sel == 3);

    ad9361_axis_pktzr #(.PKT_BEATS(4))  u0 (.clk(clk), .rst(rst), .s_axis(si0), .m_axis(mi0), .pkt_count(pc0));
    ad9361_axis_pktzr #(.PKT_BEATS(64)) u1 (.clk(clk), .rst(rst), .s_axis(si1), .m_axis(mi1), .pkt_count(pc1));
    ad9361_axis_pktzr #(.PKT_BEATS(1))  u2 (.clk(clk), .rst(rst), .s_axis(si2), .m_axis(mi2), .pkt_count(pc2));
    ad9361_axis_pktzr #(.PKT_BEATS(2))  u3 (.clk(clk), .rst(rst), .s_axis(si3), .m_axis(mi3), .pkt_count(pc3));

    always_comb begin
        o_valid = mi0.tvalid; o_last = mi0.tlast; o_data = mi0.tdata; s_ready = si0.tready; o_cnt = pc0;
        case (sel)
            1: begin o_valid = mi1.tvalid; o_last = mi1.tlast; o_data = mi1.tdata; s_ready = si1.tready; o_cnt = pc1; end
            2: begin o_valid = mi2.tvalid; o_last = mi2.tlast; o_data = mi2.tdata; s_ready = si2.tready; o_cnt = pc2; end
            3: begin o_valid = mi3.tvalid; o_last = mi3.tlast; o_data = mi3.tdata; s_ready = si3.tready; o_cnt = pc3; end
            default: ;
        endcase
    end

    // Reference model state
    int           total = 0, bad = 0;
    logic [127:0] in_q[$];
    logic [63:0]  hdr_ts[$];
    int           pos, pb, mode;
    logic [31:0]  exp_seq;
    longint       cyc, start;
    bit           busy, pend_in;
    logic [127:0] prev_data, acc, nxt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input int s);
        case (s)
            0: return 4;
            1: return 64;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [127:0] next_data(input logic [127:0] cur);
        case (mode)
            0: return cur + 128'd1;
            1: return {$urandom, $urandom, $urandom, $urandom};
            default: return (cur == PAT_A) ? PAT_B : PAT_A;
        endcase
    endfunction

    // Sample one cycle (called #1 after the falling edge, inputs already driven).
    task automatic observe();
        bit sh, mh;
        logic [127:0] e;
        sh = sv && s_ready;
        mh = o_valid && mr;
        chk("pkt_count", o_cnt, exp_seq);
        if (busy) begin
            chk("hold_valid", o_valid, 1'b1);
            chk("hold_data", o_data, prev_data);
        end else if (o_valid) begin
            start = cyc;
        end
        if (o_valid && pos == 0) chk("hdr_sready", s_ready, 1'b0);
        if (sh) in_q.push_back(sd);
        if (mh) begin
            if (pos == 0) begin
                chk("hdr_sync", o_data[127:96], SYNC);
                chk("hdr_seq", o_data[95:64], exp_seq);
                chk("hdr_ts", o_data[63:0], 128'(start - 1));
                chk("hdr_tlast", o_last, 1'b0);
                hdr_ts.push_back(o_data[63:0]);
                acc = '0;
                pos = 1;
            end else if (pos <= pb) begin
                e = (in_q.size() > 0) ? in_q.pop_front() : 'x;
                chk("pay_data", o_data, e);
                chk("pay_tlast", o_last, (pos == pb && TRL == 0));
                acc = acc ^ e;
                if (pos == pb && TRL == 0) begin
                    pos = 0;
                    exp_seq++;
                end else begin
                    pos++;
                end
            end else begin
                chk("trl_data", o_data, acc);
                chk("trl_tlast", o_last, 1'b1);
                pos = 0;
                exp_seq++;
            end
        end
        busy      = o_valid && !mr;
        prev_data = o_data;
        pend_in   = sv && !sh;
        if (sh) nxt = next_data(nxt);
    endtask

    task automatic step(input bit want_v, input bit want_r);
        sv = pend_in | want_v;   // an offered beat stays offered until taken
        mr = want_r;
        sd = nxt;
        #1;
        observe();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1; sv = 1'b0; mr = 1'b0; sel = s; pb = beats_of(s);
        #1;
        chk("rst_mvalid", o_valid, 1'b0);
        chk("rst_mlast", o_last, 1'b0);
        chk("rst_mdata", o_data, 128'd0);
        chk("rst_sready", s_ready, 1'b0);
        chk("rst_cnt", o_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_q.delete(); hdr_ts.delete();
        pos = 0; exp_seq = '0; cyc = 0; start = 0;
        busy = 0; pend_in = 0; acc = '0; prev_data = '0;
    endtask

    task automatic run_pkts(input int n, input int maxc, input int pv, input int pr);
        int c;
        c = 0;
        while (exp_seq != 32'(n) && c < maxc) begin
            step($urandom_range(99) < pv, $urandom_range(99) < pr);
            c++;
        end
        chk("run_done", exp_seq, 32'(n));
    endtask

    task automatic chk_period(input int d);
        for (int i = 1; i < hdr_ts.size(); i++)
            chk("hdr_period", hdr_ts[i] - hdr_ts[i-1], 64'(d));
    endtask

    initial begin
        sel = 0; sv = 0; mr = 0; sd = '0; mode = 0; nxt = '0;

        // Continuous traffic, PKT_BEATS=4, payload = beat index
        do_reset(0);
        run_pkts(2, 40, 100, 100);
        chk("pkt_count_two", o_cnt, 32'd2);
        chk("period_4", hdr_ts.size(), 2);
        chk_period(4 + 2 + TRL);

        // Header held 5 clk while downstream stalls
        step(1, 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("stall_no_consume", in_q.size(), 0);
        run_pkts(3, 40, 100, 100);

        // PKT_BEATS=1 continuous: header / payload+tlast, period 3
        do_reset(2);
        run_pkts(6, 60, 100, 100);
        chk_period(1 + 2 + TRL);

        // Random 50% valid/ready, PKT_BEATS=64, random data
        do_reset(1);
        mode = 1; nxt = next_data('0);
        run_pkts(150, 60000, 50, 50);
        chk("rand_drained", in_q.size(), 0);

        // Reset mid-payload after 10 beats, then restart from seq 0 / ts 0
        do_reset(1);
        mode = 0; nxt = '0;
        for (int i = 0; i < 40 && pos != 11; i++) step(1, 1);
        chk("midpay_pos", pos, 11);
        do_reset(1);
        run_pkts(1, 200, 100, 100);
        chk("rst_hdr_ts", hdr_ts[0], 64'd0);

        // Two-beat packets with alternating F0F0/0FF0 payloads (trailer case)
        do_reset(3);
        mode = 2; nxt = PAT_A;
        run_pkts(3, 60, 100, 100);
        chk_period(2 + 2 + TRL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
